// File: rtl/pwm_decoder_pkg.sv
// Constants and state encoding shared by the PWM generator and decoder.
package pwm_decoder_pkg;
  localparam int PWM_PERIOD_LOG2 = 5;
  localparam int SPEED_CODE_W    = 3;
  localparam int STEP_SHIFT      = PWM_PERIOD_LOG2 - SPEED_CODE_W;

  typedef enum logic [1:0] {FLUSH, ACQUIRE, CONFIRM, LOCKED} dec_state_e;
endpackage

// File: rtl/pwm_decoder_sync_bit.sv
// Single-bit input synchronizer; STAGES flops, synchronous clear.
// Latency STAGES clocks; no backpressure.
module pwm_decoder_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic clear,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (clear) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/pwm_decoder.sv
// Recovers a speed code from a fixed-period PWM input; publishes after two agreeing windows.
// Latency 3 windows from reset release; no backpressure.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int CNT_WIDTH   = PWM_PERIOD_LOG2,
  parameter int CODE_WIDTH  = SPEED_CODE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  enable,
  input  logic                  pwm_in,
  output logic [CODE_WIDTH-1:0] speed,
  output logic                  valid,
  output logic                  speed_changed,
  output logic                  stuck_high
);
  localparam int SHIFT = (CNT_WIDTH == PWM_PERIOD_LOG2 && CODE_WIDTH == SPEED_CODE_W)
                         ? STEP_SHIFT : CNT_WIDTH - CODE_WIDTH;
  localparam int HW = CNT_WIDTH + 1;
  localparam int TW = CNT_WIDTH + 2;
  localparam logic [TW-1:0] FULL     = TW'(1) << CNT_WIDTH;
  localparam logic [TW-1:0] HALF     = TW'(1) << (SHIFT - 1);
  localparam logic [TW-1:0] MAX_CODE = TW'((1 << CODE_WIDTH) - 1);

  logic                  s;
  logic [CNT_WIDTH-1:0]  window_cnt;
  logic [HW-1:0]         high_cnt;
  logic [CODE_WIDTH-1:0] candidate;
  dec_state_e            state;
  logic                  window_end;
  logic [TW-1:0]         total;
  logic [TW-1:0]         rounded;
  logic [CODE_WIDTH-1:0] meas;

  pwm_decoder_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .clear (enable),
    .d     (pwm_in),
    .q     (s)
  );

  // Window total includes the current sample so the count closes on the last cycle.
  always_comb begin
    window_end = (window_cnt == '1);
    total      = TW'(high_cnt) + TW'(s);
    rounded    = (total + HALF) >> SHIFT;
    meas       = (rounded > MAX_CODE) ? CODE_WIDTH'(MAX_CODE) : CODE_WIDTH'(rounded);
  end

  always_ff @(posedge clock) begin
    if (enable) begin
      window_cnt    <= '0;
      high_cnt      <= '0;
      candidate     <= '0;
      state         <= FLUSH;
      speed         <= '0;
      valid         <= 1'b0;
      speed_changed <= 1'b0;
      stuck_high    <= 1'b0;
    end else begin
      window_cnt    <= window_cnt + CNT_WIDTH'(1);
      speed_changed <= 1'b0;
      if (window_end) begin
        high_cnt <= '0;
        if (state != FLUSH) stuck_high <= (total == FULL);
        case (state)
          FLUSH: state <= ACQUIRE;
          ACQUIRE: begin
            candidate <= meas;
            state     <= CONFIRM;
          end
          CONFIRM: begin
            if (meas == candidate) begin
              speed         <= meas;
              valid         <= 1'b1;
              speed_changed <= (meas != speed) || !valid;
              state         <= LOCKED;
            end else if (valid && meas == speed) begin
              state <= LOCKED;
            end else begin
              candidate <= meas;
            end
          end
          LOCKED: begin
            if (meas != speed) begin
              candidate <= meas;
              state     <= CONFIRM;
            end
          end
          default: state <= FLUSH;
        endcase
      end else begin
        high_cnt <= high_cnt + HW'(s);
      end
    end
  end
endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: vector table, hand-written corner sequences and random segments vs a window-level model.
module tb_pwm_decoder;
  logic       clock;
  logic       enable;
  logic       pwm_in;
  logic [2:0] speed;
  logic       valid;
  logic       speed_changed;
  logic       stuck_high;

  pwm_decoder dut (
    .clock         (clock),
    .enable        (enable),
    .pwm_in        (pwm_in),
    .speed         (speed),
    .valid         (valid),
    .speed_changed (speed_changed),
    .stuck_high    (stuck_high)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: window totals from the raw sample history, two agreeing windows publish.
  int  m_n, m_speed, m_prev, m_windows, m_tot, m_meas;
  bit  m_valid, m_changed, m_stuck, m_have_prev;
  bit  hist[$];

  always @(posedge clock) begin
    if (enable) begin
      m_n = 0; hist.delete();
      m_speed = 0; m_valid = 0; m_changed = 0; m_stuck = 0;
      m_have_prev = 0; m_windows = 0; m_prev = 0;
    end else begin
      m_n++;
      hist.push_back(pwm_in);
      m_changed = 0;
      if (m_n % 32 == 0) begin
        // The synchronizer delays samples by two edges; anything before release reads 0.
        m_tot = 0;
        for (int i = m_n - 33; i <= m_n - 2; i++)
          if (i >= 1) m_tot += int'(hist[i-1]);
        m_meas = (m_tot + 2) / 4;
        if (m_meas > 7) m_meas = 7;
        m_windows++;
        if (m_windows > 1) begin
          m_stuck = (m_tot == 32);
          if (m_have_prev && m_meas == m_prev) begin
            if (!m_valid || m_meas != m_speed) m_changed = 1;
            m_speed = m_meas;
            m_valid = 1;
          end
          m_prev      = m_meas;
          m_have_prev = 1;
        end
      end
    end
  end

  // Source: 0 = PWM(code, phase), 1 = const high, 2 = const low, 3 = toggle
  int src_kind, src_code, src_phase, t, pulses, first_pulse, step_idx;

  function automatic bit src_val();
    case (src_kind)
      0:       return ((t + src_phase) % 32) < 4 * src_code;
      1:       return 1'b1;
      2:       return 1'b0;
      default: return t[0];
    endcase
  endfunction

  task automatic step(input bit en);
    @(negedge clock);
    check("speed",         int'(speed),         m_speed);
    check("valid",         int'(valid),         int'(m_valid));
    check("speed_changed", int'(speed_changed), int'(m_changed));
    check("stuck_high",    int'(stuck_high),    int'(m_stuck));
    step_idx++;
    if (speed_changed === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = step_idx;
    end
    t++;
    enable = en;
    pwm_in = src_val();
  endtask

  task automatic set_src(input int kind, input int code, input int phase);
    src_kind = kind; src_code = code; src_phase = phase;
    pulses = 0; first_pulse = -1; step_idx = 0;
  endtask

  typedef struct {
    int kind; int code; int phase; int cycles;
    int exp_speed; bit exp_valid; bit exp_stuck; int exp_pulses;
  } vec_t;

  vec_t vecs[15];

  task automatic run_vec(input int idx);
    set_src(vecs[idx].kind, vecs[idx].code, vecs[idx].phase);
    for (int k = 0; k < vecs[idx].cycles; k++) step(1'b0);
    check($sformatf("vec%0d_speed", idx),  int'(speed),      vecs[idx].exp_speed);
    check($sformatf("vec%0d_valid", idx),  int'(valid),      int'(vecs[idx].exp_valid));
    check($sformatf("vec%0d_stuck", idx),  int'(stuck_high), int'(vecs[idx].exp_stuck));
    check($sformatf("vec%0d_pulses", idx), pulses,           vecs[idx].exp_pulses);
    if (vecs[idx].exp_pulses == 1)
      check($sformatf("vec%0d_latency_le_97", idx),
            int'(first_pulse >= 1 && first_pulse <= 97), 1);
  endtask

  initial begin
    enable = 1'b1;
    pwm_in = 1'b0;
    t = 0;
    vecs[0]  = '{0, 0,  3, 256, 0, 1, 0, 1};
    vecs[1]  = '{0, 1, 17, 256, 1, 1, 0, 1};
    vecs[2]  = '{0, 2,  5, 256, 2, 1, 0, 1};
    vecs[3]  = '{0, 3, 30, 256, 3, 1, 0, 1};
    vecs[4]  = '{0, 4,  9, 256, 4, 1, 0, 1};
    vecs[5]  = '{0, 5, 22, 256, 5, 1, 0, 1};
    vecs[6]  = '{0, 6,  0, 256, 6, 1, 0, 1};
    vecs[7]  = '{0, 7, 13, 256, 7, 1, 0, 1};
    vecs[8]  = '{0, 5,  7, 256, 5, 1, 0, 1};
    vecs[9]  = '{0, 2, 19, 256, 2, 1, 0, 1};
    vecs[10] = '{0, 6, 11, 256, 6, 1, 0, 1};
    vecs[11] = '{1, 0,  0, 256, 7, 1, 1, 1};
    vecs[12] = '{0, 3,  4, 256, 3, 1, 0, 1};
    vecs[13] = '{2, 0,  0, 256, 0, 1, 0, 1};
    vecs[14] = '{0, 4, 25, 256, 4, 1, 0, 1};

    // Reset held with a toggling input
    set_src(3, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      check("rst_speed", int'(speed), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_changed", int'(speed_changed), 0);
      check("rst_stuck", int'(stuck_high), 0);
    end

    for (int v = 0; v <= 10; v++) run_vec(v);

    // Window-aligned low glitch while locked at 6
    for (int g = 0; g < 40 && ((m_n + 2) % 32) != 31; g++) step(1'b0);
    src_kind = 2; pulses = 0;
    for (int k = 0; k < 32; k++) step(1'b0);
    src_kind = 0;
    for (int k = 0; k < 96; k++) step(1'b0);
    check("glitch_pulses", pulses, 0);
    check("glitch_speed", int'(speed), 6);
    check("glitch_valid", int'(valid), 1);

    for (int v = 11; v <= 14; v++) run_vec(v);

    // Reset pulse mid-window while locked at 4, then relock timing
    for (int g = 0; g < 40 && (m_n % 32) != 15; g++) step(1'b0);
    step(1'b1);
    step(1'b0);
    check("midrst_speed", int'(speed), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_stuck", int'(stuck_high), 0);
    for (int j = 2; j <= 97; j++) begin
      step(1'b0);
      if (j == 96) check("relock_valid_edge95", int'(valid), 0);
      if (j == 97) begin
        check("relock_valid_edge96", int'(valid), 1);
        check("relock_speed", int'(speed), 4);
        check("relock_pulse", int'(speed_changed), 1);
      end
    end

    // Random segments against the model
    for (int r = 0; r < 25; r++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 9) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'b1);
      end else begin
        src_kind  = (sel <= 6) ? 0 : (sel == 7 ? 1 : 2);
        src_code  = int'($urandom_range(0, 7));
        src_phase = int'($urandom_range(0, 31));
        for (int k = 0; k < int'($urandom_range(5, 300)); k++) step(1'b0);
      end
    end
    for (int k = 0; k < 10; k++) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
